// File: rtl/odometer_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : odometer_sweep_ctrl
// Purpose  : Walks a range of odometer indices. For each index it writes the
//            stress config, holds and releases stress, runs measure/load, and
//            pushes {index, bit_count} into a small result FIFO.
// Options  : ODO_SWEEP_SWEEPID_EN - when defined, each result is tagged with
//            an 8-bit sweep counter, giving {sweep_id, index, bit_count}.
// Revision : 1.0 - initial release
// ============================================================================
module odometer_sweep_ctrl #(
  parameter int NUM_ODOMETER      = 21,
  parameter int NUM_ODOMETER_LOG2 = $clog2(NUM_ODOMETER),
  parameter int CNT_W             = 16,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                         stream_clk,
  input  logic                         odometer_bus_resetb,
  input  logic                         start,
  input  logic                         abort,
  input  logic [NUM_ODOMETER_LOG2-1:0] first_sel,
  input  logic [NUM_ODOMETER_LOG2-1:0] last_sel,
  input  logic [CNT_W-1:0]             stress_cycles,
  input  logic [CNT_W-1:0]             meas_cycles,
  input  logic                         cfg_ac_dc,
  input  logic [2:0]                   cfg_sel,
  output logic [NUM_ODOMETER_LOG2-1:0] odometer_sel,
  output logic                         odometer_enable,
  output logic                         stress,
  output logic                         ac_dc,
  output logic                         sel_inv,
  output logic                         sel_nand,
  output logic                         sel_nor,
  output logic                         odometer_meas_trig,
  output logic                         odometer_load,
  input  logic [11:0]                  bit_count,
  output logic                         result_valid,
  input  logic                         result_ready,
`ifdef ODO_SWEEP_SWEEPID_EN
  output logic [8+NUM_ODOMETER_LOG2+12-1:0] result_data,
`else
  output logic [NUM_ODOMETER_LOG2+12-1:0]   result_data,
`endif
  output logic                         busy,
  output logic                         done,
  output logic                         range_err
);

  localparam int W     = NUM_ODOMETER_LOG2;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef ODO_SWEEP_SWEEPID_EN
  localparam int RES_W = 8 + W + 12;
`else
  localparam int RES_W = W + 12;
`endif
  localparam logic [W:0]       LAST_LIMIT    = (W+1)'(NUM_ODOMETER);
  localparam logic [PTR_W:0]   FIFO_FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE       = (PTR_W+1)'(1);
  localparam logic [CNT_W-1:0] TMR_ONE       = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_CFG, S_STRESS, S_UNSTRESS, S_MEAS, S_LOAD,
    S_SETTLE, S_CAPTURE, S_NEXT, S_DONE, S_CLEAR
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_idx;
  logic [W-1:0]     r_last;
  logic [CNT_W-1:0] r_stress_cfg;
  logic [CNT_W-1:0] r_meas_cfg;
  logic [CNT_W-1:0] r_cnt;

  logic [RES_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic             w_pop;
  logic             w_can_push;
  logic             w_push;
  logic             w_abort;
  logic             w_range_ok;
  logic [RES_W-1:0] w_push_data;
  logic [PTR_W-1:0] w_rd_next;
  logic [PTR_W:0]   w_count_next;
  logic [PTR_W:0]   w_count_after_pop;

  // A full FIFO can still accept a capture when the host pops in the same cycle.
  assign w_pop      = result_valid && result_ready;
  assign w_can_push = (r_count != FIFO_FULL_CNT) || w_pop;
  assign w_abort    = abort && (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_CLEAR);
  assign w_push     = (r_state == S_CAPTURE) && !w_abort && w_can_push;
  assign w_range_ok = (first_sel <= last_sel) && ({1'b0, last_sel} < LAST_LIMIT);

`ifdef ODO_SWEEP_SWEEPID_EN
  logic [7:0] r_sweep_id;

  // Sweep tag advances once per completed sweep; aborted sweeps keep the tag.
  always_ff @(posedge stream_clk or negedge odometer_bus_resetb) begin
    if (!odometer_bus_resetb) r_sweep_id <= 8'd0;
    else if (r_state == S_DONE) r_sweep_id <= r_sweep_id + 8'd1;
  end

  assign w_push_data = {r_sweep_id, r_idx, bit_count};
`else
  assign w_push_data = {r_idx, bit_count};
`endif

  // Sequencer: every bus output is set on entry to the state that owns it.
  always_ff @(posedge stream_clk or negedge odometer_bus_resetb) begin
    if (!odometer_bus_resetb) begin
      r_state            <= S_IDLE;
      r_idx              <= '0;
      r_last             <= '0;
      r_stress_cfg       <= '0;
      r_meas_cfg         <= '0;
      r_cnt              <= '0;
      odometer_sel       <= '0;
      odometer_enable    <= 1'b0;
      stress             <= 1'b0;
      ac_dc              <= 1'b0;
      {sel_inv, sel_nand, sel_nor} <= 3'b000;
      odometer_meas_trig <= 1'b0;
      odometer_load      <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      range_err          <= 1'b0;
    end else begin
      odometer_enable    <= 1'b0;
      stress             <= 1'b0;
      odometer_meas_trig <= 1'b0;
      odometer_load      <= 1'b0;
      done               <= 1'b0;
      if (w_abort) begin
        // Leave the current odometer unstressed before dropping back to idle.
        r_state         <= S_CLEAR;
        odometer_enable <= 1'b1;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              if (w_range_ok) begin
                range_err       <= 1'b0;
                r_idx           <= first_sel;
                r_last          <= last_sel;
                r_stress_cfg    <= stress_cycles;
                r_meas_cfg      <= (meas_cycles == '0) ? TMR_ONE : meas_cycles;
                odometer_sel    <= first_sel;
                odometer_enable <= 1'b1;
                stress          <= (stress_cycles != '0);
                ac_dc           <= cfg_ac_dc;
                {sel_inv, sel_nand, sel_nor} <= cfg_sel;
                busy            <= 1'b1;
                r_state         <= S_CFG;
              end else begin
                range_err <= 1'b1;
              end
            end
          end
          S_CFG: begin
            if (r_stress_cfg != '0) begin
              r_cnt   <= r_stress_cfg - TMR_ONE;
              r_state <= S_STRESS;
            end else begin
              r_cnt              <= r_meas_cfg - TMR_ONE;
              odometer_meas_trig <= 1'b1;
              r_state            <= S_MEAS;
            end
          end
          S_STRESS: begin
            if (r_cnt == '0) begin
              odometer_enable <= 1'b1;
              r_state         <= S_UNSTRESS;
            end else begin
              r_cnt <= r_cnt - TMR_ONE;
            end
          end
          S_UNSTRESS: begin
            r_cnt              <= r_meas_cfg - TMR_ONE;
            odometer_meas_trig <= 1'b1;
            r_state            <= S_MEAS;
          end
          S_MEAS: begin
            if (r_cnt == '0) begin
              odometer_load <= 1'b1;
              r_state       <= S_LOAD;
            end else begin
              r_cnt              <= r_cnt - TMR_ONE;
              odometer_meas_trig <= 1'b1;
            end
          end
          S_LOAD: begin
            r_cnt   <= TMR_ONE;
            r_state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (r_cnt == '0) r_state <= S_CAPTURE;
            else             r_cnt   <= r_cnt - TMR_ONE;
          end
          S_CAPTURE: begin
            // No room means wait here; results are never dropped.
            if (w_can_push) r_state <= S_NEXT;
          end
          S_NEXT: begin
            if (r_idx == r_last) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_idx           <= r_idx + W'(1);
              odometer_sel    <= r_idx + W'(1);
              odometer_enable <= 1'b1;
              stress          <= (r_stress_cfg != '0);
              r_state         <= S_CFG;
            end
          end
          default: begin
            // DONE and CLEAR both return to idle with the bus quiet.
            odometer_sel <= '0;
            ac_dc        <= 1'b0;
            {sel_inv, sel_nand, sel_nor} <= 3'b000;
            busy         <= 1'b0;
            r_state      <= S_IDLE;
          end
        endcase
      end
    end
  end

  // Occupancy bookkeeping and next head pointer for the registered head view.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop)      w_count_next = r_count + CNT_ONE;
    else if (!w_push && w_pop) w_count_next = r_count - CNT_ONE;
    w_count_after_pop = w_pop ? (r_count - CNT_ONE) : r_count;
    w_rd_next         = w_pop ? (r_rd_ptr + PTR_W'(1)) : r_rd_ptr;
  end

  // Result FIFO; result_data is registered and always shows the head entry.
  always_ff @(posedge stream_clk or negedge odometer_bus_resetb) begin
    if (!odometer_bus_resetb) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      result_valid <= 1'b0;
      result_data  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr     <= w_rd_next;
      r_count      <= w_count_next;
      result_valid <= (w_count_next != '0);
      // When the FIFO drains to nothing but a push lands, the new entry is head.
      result_data  <= (w_count_after_pop == '0) ? w_push_data : r_mem[w_rd_next];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_odometer_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_odometer_sweep_ctrl
// Purpose  : Directed self-checking bench for odometer_sweep_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_odometer_sweep_ctrl;

  localparam int W = 5;
`ifdef ODO_SWEEP_SWEEPID_EN
  localparam int RW = 8 + W + 12;
`else
  localparam int RW = W + 12;
`endif

  logic          stream_clk;
  logic          odometer_bus_resetb;
  logic          start, abort;
  logic [W-1:0]  first_sel, last_sel;
  logic [15:0]   stress_cycles, meas_cycles;
  logic          cfg_ac_dc;
  logic [2:0]    cfg_sel;
  logic [W-1:0]  odometer_sel;
  logic          odometer_enable, stress, ac_dc, sel_inv, sel_nand, sel_nor;
  logic          odometer_meas_trig, odometer_load;
  logic [11:0]   bit_count;
  logic          result_valid, result_ready;
  logic [RW-1:0] result_data;
  logic          busy, done, range_err;

  odometer_sweep_ctrl dut (
    .stream_clk(stream_clk), .odometer_bus_resetb(odometer_bus_resetb),
    .start(start), .abort(abort), .first_sel(first_sel), .last_sel(last_sel),
    .stress_cycles(stress_cycles), .meas_cycles(meas_cycles),
    .cfg_ac_dc(cfg_ac_dc), .cfg_sel(cfg_sel), .odometer_sel(odometer_sel),
    .odometer_enable(odometer_enable), .stress(stress), .ac_dc(ac_dc),
    .sel_inv(sel_inv), .sel_nand(sel_nand), .sel_nor(sel_nor),
    .odometer_meas_trig(odometer_meas_trig), .odometer_load(odometer_load),
    .bit_count(bit_count), .result_valid(result_valid),
    .result_ready(result_ready), .result_data(result_data),
    .busy(busy), .done(done), .range_err(range_err)
  );

  // Odometer array stand-in: each index reads back a distinct count.
  assign bit_count = 12'h100 + 12'(odometer_sel) * 12'd3;

  initial stream_clk = 1'b0;
  always #5 stream_clk = ~stream_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Bus/result monitor, sampled on the falling edge.
  int          cyc = 0;
  logic [9:0]  wr_q[$];
  int          wr_cyc[$];
  logic [RW-1:0] res_q[$];
  int          n_meas = 0, n_load = 0, n_done = 0;

  always @(negedge stream_clk) begin
    cyc++;
    if (odometer_enable) begin
      wr_q.push_back({odometer_sel, stress, ac_dc, sel_inv, sel_nand, sel_nor});
      wr_cyc.push_back(cyc);
    end
    if (odometer_meas_trig) n_meas++;
    if (odometer_load) n_load++;
    if (done) n_done++;
    if (result_valid && result_ready) res_q.push_back(result_data);
  end

  function automatic logic [31:0] get_wr(input int i);
    return (i < wr_q.size()) ? 32'(wr_q[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] get_res(input int i);
    return (i < res_q.size()) ? 32'(res_q[i]) : 32'hFFFF_FFFF;
  endfunction
  function automatic logic [31:0] exp_res(input int idx, input int sid);
    logic [W-1:0] i;
    logic [11:0]  bc;
    logic [7:0]   s;
    i  = W'(idx);
    bc = 12'h100 + 12'(idx * 3);
    s  = 8'(sid);
`ifdef ODO_SWEEP_SWEEPID_EN
    return 32'({s, i, bc});
`else
    if (s == 8'hFF) return 32'hFFFF_FFFF;
    return 32'({i, bc});
`endif
  endfunction

  task automatic tick();
    @(posedge stream_clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k;
    k = 0;
    while (busy !== 1'b0 && k < budget) begin
      tick();
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic setup(input int f, input int l, input int s, input int m,
                       input logic ad, input logic [2:0] cs, input logic rdy);
    first_sel     = W'(f);
    last_sel      = W'(l);
    stress_cycles = 16'(s);
    meas_cycles   = 16'(m);
    cfg_ac_dc     = ad;
    cfg_sel       = cs;
    result_ready  = rdy;
  endtask

  int bw, br, bd, bm, bl, k;
  logic found;

  initial begin
    odometer_bus_resetb = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    setup(0, 0, 0, 0, 1'b0, 3'b000, 1'b0);
    repeat (3) @(posedge stream_clk);
    #2 odometer_bus_resetb = 1'b1;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_enable", 32'(odometer_enable), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_range_err", 32'(range_err), 32'd0);
    check("rst_sel", 32'(odometer_sel), 32'd0);

    // Stressed three-odometer sweep.
    setup(3, 5, 10, 4, 1'b1, 3'b100, 1'b1);
    bw = wr_q.size(); br = res_q.size(); bd = n_done;
    pulse_start();
    wait_idle("t1_idle", 200);
    check("t1_writes", 32'(wr_q.size() - bw), 32'd6);
    check("t1_cfg_wr", get_wr(bw), 32'({5'd3, 1'b1, 1'b1, 3'b100}));
    check("t1_unstress_wr", get_wr(bw + 1), 32'({5'd3, 1'b0, 1'b1, 3'b100}));
    check("t1_stress_hold", 32'(wr_cyc[bw + 1] - wr_cyc[bw]), 32'd11);
    check("t1_period", 32'(wr_cyc[bw + 2] - wr_cyc[bw]), 32'd21);
    check("t1_done", 32'(n_done - bd), 32'd1);
    for (int i = 0; i < 3; i++) check("t1_res", get_res(br + i), exp_res(3 + i, 0));

    // Single odometer, no stress, zero measure time.
    setup(7, 7, 0, 0, 1'b0, 3'b010, 1'b1);
    bw = wr_q.size(); br = res_q.size(); bd = n_done; bm = n_meas; bl = n_load;
    pulse_start();
    wait_idle("t2_idle", 100);
    check("t2_writes", 32'(wr_q.size() - bw), 32'd1);
    check("t2_cfg_wr", get_wr(bw), 32'({5'd7, 1'b0, 1'b0, 3'b010}));
    check("t2_meas", 32'(n_meas - bm), 32'd1);
    check("t2_load", 32'(n_load - bl), 32'd1);
    check("t2_res", get_res(br), exp_res(7, 1));
    check("t2_done", 32'(n_done - bd), 32'd1);

    // Bad ranges: last beyond the array, then first after last.
    setup(20, 21, 1, 1, 1'b0, 3'b001, 1'b1);
    bw = wr_q.size();
    pulse_start();
    check("t3_err_limit", 32'(range_err), 32'd1);
    check("t3_busy_limit", 32'(busy), 32'd0);
    setup(6, 2, 1, 1, 1'b0, 3'b001, 1'b1);
    pulse_start();
    repeat (3) tick();
    check("t3_err_order", 32'(range_err), 32'd1);
    check("t3_busy_order", 32'(busy), 32'd0);
    check("t3_no_writes", 32'(wr_q.size() - bw), 32'd0);

    // Backpressure: host not ready, FIFO fills and the sweep stalls.
    setup(0, 5, 2, 1, 1'b1, 3'b001, 1'b0);
    br = res_q.size(); bd = n_done;
    pulse_start();
    check("t4_err_clear", 32'(range_err), 32'd0);
    check("t4_busy", 32'(busy), 32'd1);
    repeat (100) tick();
    check("t4_stall_busy", 32'(busy), 32'd1);
    check("t4_stall_sel", 32'(odometer_sel), 32'd4);
    check("t4_stall_valid", 32'(result_valid), 32'd1);
    check("t4_stall_done", 32'(n_done - bd), 32'd0);
    result_ready = 1'b1;
    wait_idle("t4_idle", 200);
    repeat (2) tick();
    check("t4_count", 32'(res_q.size() - br), 32'd6);
    for (int i = 0; i < 6; i++) check("t4_res", get_res(br + i), exp_res(i, 2));

    // Abort while stressing index 2.
    setup(1, 3, 20, 1, 1'b0, 3'b001, 1'b1);
    br = res_q.size(); bd = n_done;
    pulse_start();
    found = 1'b0;
    for (k = 0; k < 200 && !found; k++) begin
      @(negedge stream_clk);
      if (odometer_enable && odometer_sel == W'(2) && stress) found = 1'b1;
    end
    check("t5_found", 32'(found), 32'd1);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_clr_enable", 32'(odometer_enable), 32'd1);
    check("t5_clr_stress", 32'(stress), 32'd0);
    check("t5_clr_sel", 32'(odometer_sel), 32'd2);
    tick();
    check("t5_idle", 32'(busy), 32'd0);
    check("t5_idle_enable", 32'(odometer_enable), 32'd0);
    repeat (3) tick();
    check("t5_no_done", 32'(n_done - bd), 32'd0);
    check("t5_count", 32'(res_q.size() - br), 32'd1);
    check("t5_res", get_res(br), exp_res(1, 3));

    // abort alongside start in idle: start wins.
    setup(0, 0, 0, 1, 1'b0, 3'b001, 1'b1);
    abort = 1'b1;
    pulse_start();
    abort = 1'b0;
    check("t5b_busy", 32'(busy), 32'd1);
    wait_idle("t5b_idle", 100);

    // Asynchronous reset in the middle of a measurement.
    setup(0, 2, 0, 3, 1'b0, 3'b001, 1'b0);
    pulse_start();
    found = 1'b0;
    for (k = 0; k < 200 && !found; k++) begin
      @(negedge stream_clk);
      if (odometer_meas_trig && odometer_sel == W'(1)) found = 1'b1;
    end
    check("t6_found", 32'(found), 32'd1);
    check("t6_pre_valid", 32'(result_valid), 32'd1);
    #1 odometer_bus_resetb = 1'b0;
    #1;
    check("t6_meas", 32'(odometer_meas_trig), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_sel", 32'(odometer_sel), 32'd0);
    check("t6_valid", 32'(result_valid), 32'd0);
    tick();
    odometer_bus_resetb = 1'b1;
    tick();
    check("t6_after_busy", 32'(busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
